// File: rtl/hbm_bench_pkg.sv
// Shared types and constants for the HBM test sequencer.
// Holds the FSM state encoding, the run-mode and error-code encodings,
// the default watchdog timeout and a small state-classification helper.
package hbm_bench_pkg;

    localparam int TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_DRAIN = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_DRAIN = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_WR      = 2'd0,
        MODE_RD      = 2'd1,
        MODE_WR_RD   = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RESP    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_MODE    = 2'd3
    } err_e;

    // True for the four states in which traffic is in flight.
    function automatic logic is_active(input state_e s);
        case (s)
            ST_WR_ISSUE, ST_WR_DRAIN, ST_RD_ISSUE, ST_RD_DRAIN: is_active = 1'b1;
            default:                                            is_active = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hbm_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (count -> 0)
//   clr   - synchronous clear, wins over en
//   en    - advance by one unless already at all-ones
//   count - registered count value
module hbm_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clear has priority, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hbm_test_sequencer.sv
// HBM test sequencer: gates an external AXI3 traffic master through a
// write phase and/or a read phase of num_bursts bursts each, measures the
// duration of each phase, flags bad responses and aborts stalled runs.
// Ports:
//   aclk, aresetn            - clock, asynchronous active-low reset
//   start, mode, num_bursts  - run request (mode: 0 wr, 1 rd, 2 wr+rd, 3 illegal)
//   aw_hs, b_hs, ar_hs, rlast_hs - handshake strobes from the master
//   bresp, rresp             - response codes, sampled with b_hs / rlast_hs
//   wr_issue_en, rd_issue_en - permission for the master to issue addresses
//   busy, done, err_code     - run status (done is a one-cycle pulse)
//   wr_cycles, rd_cycles     - measured phase durations
module hbm_test_sequencer
    import hbm_bench_pkg::*;
#(
    parameter int NB_W    = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [NB_W-1:0]  num_bursts,
    input  logic             aw_hs,
    input  logic             b_hs,
    input  logic             ar_hs,
    input  logic             rlast_hs,
    input  logic [1:0]       bresp,
    input  logic [1:0]       rresp,
    output logic             wr_issue_en,
    output logic             rd_issue_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] wr_cycles,
    output logic [CNT_W-1:0] rd_cycles
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // The watchdog reads 0 in the first silent cycle, so firing at TIMEOUT-2
    // lands DONE exactly TIMEOUT cycles after the last handshake.
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 2);

    state_e          state_r;
    mode_e           mode_r;
    logic [NB_W-1:0] nb_r;
    logic [NB_W-1:0] issued_r;
    logic [NB_W-1:0] completed_r;
    err_e            err_r;
    logic            busy_r;
    logic            done_r;

    logic            active_s;
    logic            wr_phase_s;
    logic            rd_phase_s;
    logic            issue_state_s;
    logic            addr_hs_s;
    logic            resp_hs_s;
    logic [1:0]      resp_code_s;
    logic            issue_inc_s;
    logic            issue_last_s;
    logic            resp_inc_s;
    logic            phase_end_s;
    logic            any_hs_s;
    logic            start_acc_s;
    logic            wd_expire_s;
    logic [WD_W-1:0] wd_count_s;

    // Phase decode: route the strobes of whichever phase is running onto
    // common issue/response signals so one set of rules serves both phases.
    always_comb begin
        active_s      = is_active(state_r);
        wr_phase_s    = (state_r == ST_WR_ISSUE) || (state_r == ST_WR_DRAIN);
        rd_phase_s    = (state_r == ST_RD_ISSUE) || (state_r == ST_RD_DRAIN);
        issue_state_s = (state_r == ST_WR_ISSUE) || (state_r == ST_RD_ISSUE);
        if (wr_phase_s) begin
            addr_hs_s   = aw_hs;
            resp_hs_s   = b_hs;
            resp_code_s = bresp;
        end else if (rd_phase_s) begin
            addr_hs_s   = ar_hs;
            resp_hs_s   = rlast_hs;
            resp_code_s = rresp;
        end else begin
            addr_hs_s   = 1'b0;
            resp_hs_s   = 1'b0;
            resp_code_s = 2'b00;
        end
        issue_inc_s  = addr_hs_s && issue_state_s;
        issue_last_s = issue_inc_s && ((issued_r + NB_W'(1)) == nb_r);
        // A response with nothing outstanding (judged against the issued
        // count before this cycle's address) is dropped.
        resp_inc_s   = resp_hs_s && (completed_r < issued_r);
        phase_end_s  = resp_inc_s && ((completed_r + NB_W'(1)) == nb_r);
        any_hs_s     = active_s && (aw_hs || b_hs || ar_hs || rlast_hs);
        start_acc_s  = (state_r == ST_IDLE) && start;
        wd_expire_s  = active_s && !any_hs_s && (wd_count_s == WD_LIMIT);
    end

    // Sequencer FSM with its burst counters, error code and status flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_WR;
            nb_r        <= {NB_W{1'b0}};
            issued_r    <= {NB_W{1'b0}};
            completed_r <= {NB_W{1'b0}};
            err_r       <= ERR_NONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r      <= mode_e'(mode);
                        nb_r        <= num_bursts;
                        issued_r    <= {NB_W{1'b0}};
                        completed_r <= {NB_W{1'b0}};
                        busy_r      <= 1'b1;
                        if (mode_e'(mode) == MODE_ILLEGAL) begin
                            err_r   <= ERR_MODE;
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (num_bursts == {NB_W{1'b0}}) begin
                            err_r   <= ERR_NONE;
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (mode_e'(mode) == MODE_RD) begin
                            err_r   <= ERR_NONE;
                            state_r <= ST_RD_ISSUE;
                        end else begin
                            err_r   <= ERR_NONE;
                            state_r <= ST_WR_ISSUE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_ISSUE, ST_WR_DRAIN, ST_RD_ISSUE, ST_RD_DRAIN: begin
                    if (wd_expire_s) begin
                        err_r   <= ERR_TIMEOUT;
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        if (issue_inc_s) begin
                            issued_r <= issued_r + NB_W'(1);
                        end else begin
                            issued_r <= issued_r;
                        end
                        if (resp_inc_s) begin
                            completed_r <= completed_r + NB_W'(1);
                        end else begin
                            completed_r <= completed_r;
                        end
                        if (resp_hs_s && (resp_code_s != 2'b00) && (err_r != ERR_TIMEOUT)) begin
                            err_r <= ERR_RESP;
                        end else begin
                            err_r <= err_r;
                        end
                        if (phase_end_s) begin
                            if (wr_phase_s && (mode_r == MODE_WR_RD)) begin
                                // Later NBAs override the increments above.
                                issued_r    <= {NB_W{1'b0}};
                                completed_r <= {NB_W{1'b0}};
                                state_r     <= ST_RD_ISSUE;
                            end else begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end
                        end else if (issue_last_s) begin
                            state_r <= wr_phase_s ? ST_WR_DRAIN : ST_RD_DRAIN;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    hbm_sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (start_acc_s),
        .en    (wr_phase_s),
        .count (wr_cycles)
    );

    hbm_sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (start_acc_s),
        .en    (rd_phase_s),
        .count (rd_cycles)
    );

    // Every phase entry coincides with a start or a handshake, so clearing
    // on those also covers the per-state restart of the watchdog.
    hbm_sat_counter #(.W(WD_W)) u_wd_cnt (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (start_acc_s || any_hs_s),
        .en    (active_s),
        .count (wd_count_s)
    );

    assign wr_issue_en = (state_r == ST_WR_ISSUE);
    assign rd_issue_en = (state_r == ST_RD_ISSUE);
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_code    = err_r;

endmodule

// File: tb/tb_hbm_test_sequencer.sv
// Directed bench for hbm_test_sequencer: a table of whole runs driven by a
// well-behaved back-to-back master, plus hand-written reset and overlap cases.
module tb_hbm_test_sequencer;

    localparam int NB_W  = 16;
    localparam int CNT_W = 32;
    localparam int TMO   = 16;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             start;
    logic [1:0]       mode;
    logic [NB_W-1:0]  num_bursts;
    logic             aw_hs, b_hs, ar_hs, rlast_hs;
    logic [1:0]       bresp, rresp;
    logic             wr_issue_en, rd_issue_en, busy, done;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] wr_cycles, rd_cycles;

    int checks = 0;
    int errors = 0;

    hbm_test_sequencer #(.NB_W(NB_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .mode        (mode),
        .num_bursts  (num_bursts),
        .aw_hs       (aw_hs),
        .b_hs        (b_hs),
        .ar_hs       (ar_hs),
        .rlast_hs    (rlast_hs),
        .bresp       (bresp),
        .rresp       (rresp),
        .wr_issue_en (wr_issue_en),
        .rd_issue_en (rd_issue_en),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code),
        .wr_cycles   (wr_cycles),
        .rd_cycles   (rd_cycles)
    );

    always #5 aclk = ~aclk;

    // One run: inputs, then hand-computed expectations. Cycle 0 is the start
    // cycle; bad_idx is the 1-based response (each phase) that carries resp=2.
    typedef struct {
        int mode;
        int nb;
        int bad_idx;
        int rsp_lim;
        int exp_done_cyc;
        int exp_err;
        int exp_wr;
        int exp_rd;
        int exp_wr_en;
        int exp_rd_en;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_hs();
        aw_hs = 1'b0; b_hs = 1'b0; ar_hs = 1'b0; rlast_hs = 1'b0;
        bresp = 2'd0; rresp = 2'd0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, aw_n, b_n, ar_n, r_n, lim, done_at, done_cnt, seen_wr, seen_rd;
        int err_at, wr_at, rd_at;
        string tag;
        tag = $sformatf("v%0d", idx);
        lim = (v.rsp_lim < v.nb) ? v.rsp_lim : v.nb;
        aw_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        done_at = -1; done_cnt = 0; seen_wr = 0; seen_rd = 0;
        err_at = -1; wr_at = -1; rd_at = -1;
        clear_hs();
        start = 1'b1; mode = v.mode[1:0]; num_bursts = v.nb[NB_W-1:0];
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 250 && !(done_at >= 0 && cyc > done_at + 1)) begin
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                    err_at = int'(err_code);
                    wr_at = int'(wr_cycles);
                    rd_at = int'(rd_cycles);
                end
            end
            if (wr_issue_en) seen_wr = 1;
            if (rd_issue_en) seen_rd = 1;
            clear_hs();
            if (wr_issue_en && aw_n < v.nb) begin
                aw_hs = 1'b1;
            end
            if (aw_n == v.nb && b_n < lim) begin
                b_hs = 1'b1;
                bresp = (b_n + 1 == v.bad_idx) ? 2'd2 : 2'd0;
                b_n++;
            end
            if (aw_hs) aw_n++;
            if (rd_issue_en && ar_n < v.nb) begin
                ar_hs = 1'b1;
            end
            if (ar_n == v.nb && r_n < lim) begin
                rlast_hs = 1'b1;
                rresp = (r_n + 1 == v.bad_idx) ? 2'd2 : 2'd0;
                r_n++;
            end
            if (ar_hs) ar_n++;
            if (done_at >= 0 && cyc == done_at + 1) begin
                check({tag, "_idle_busy"}, int'(busy), 0);
                check({tag, "_held_err"}, int'(err_code), v.exp_err);
            end
            tick();
            cyc++;
        end
        clear_hs();
        check({tag, "_done_cycle"}, done_at, v.exp_done_cyc);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_err_code"}, err_at, v.exp_err);
        check({tag, "_wr_cycles"}, wr_at, v.exp_wr);
        check({tag, "_rd_cycles"}, rd_at, v.exp_rd);
        check({tag, "_wr_issue_seen"}, seen_wr, v.exp_wr_en);
        check({tag, "_rd_issue_seen"}, seen_rd, v.exp_rd_en);
    endtask

    initial begin
        //           mode nb bad lim done err  wr  rd wr_en rd_en
        vecs[0] = '{2,   4,  0, 99, 17,  0,  8,  8, 1, 1};
        vecs[1] = '{0,   2,  1, 99,  5,  1,  4,  0, 1, 0};
        vecs[2] = '{1,   3,  0,  2, 21,  2,  0, 20, 0, 1};
        vecs[3] = '{0,   0,  0, 99,  1,  0,  0,  0, 0, 0};
        vecs[4] = '{3,   5,  0, 99,  1,  3,  0,  0, 0, 0};
        vecs[5] = '{1,   1,  0, 99,  3,  0,  0,  2, 0, 1};
        vecs[6] = '{2,   1,  1, 99,  5,  1,  2,  2, 1, 1};
        vecs[7] = '{1,   2,  2, 99,  5,  1,  0,  4, 0, 1};
        vecs[8] = '{3,   0,  0, 99,  1,  3,  0,  0, 0, 0};

        aresetn = 1'b0; start = 1'b0; mode = 2'd0; num_bursts = '0;
        clear_hs();
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_code), 0);
        check("rst_wr_en", int'(wr_issue_en), 0);
        check("rst_rd_en", int'(rd_issue_en), 0);
        check("rst_wr_cycles", int'(wr_cycles), 0);
        check("rst_rd_cycles", int'(rd_cycles), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in WR_DRAIN with two bursts still outstanding.
        start = 1'b1; mode = 2'd0; num_bursts = 16'd4;
        tick();
        start = 1'b0;
        repeat (4) begin aw_hs = 1'b1; tick(); end
        aw_hs = 1'b0;
        check("drain_wr_en", int'(wr_issue_en), 0);
        repeat (2) begin b_hs = 1'b1; tick(); end
        b_hs = 1'b0;
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_wr_cycles", int'(wr_cycles), 6);
        aresetn = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_wr_en", int'(wr_issue_en), 0);
        check("midrst_wr_cycles", int'(wr_cycles), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(err_code), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        run_vec(100, vecs[0]);

        // Restart mid-run ignored; aw_hs and b_hs together both counted;
        // the b_hs in cycle 1 has nothing outstanding and is dropped.
        start = 1'b1; mode = 2'd0; num_bursts = 16'd3;
        tick();
        start = 1'b0;
        aw_hs = 1'b1; b_hs = 1'b1;
        tick();
        start = 1'b1; mode = 2'd1;
        tick();
        start = 1'b0;
        tick();
        aw_hs = 1'b0;
        check("ovl_drain_wr_en", int'(wr_issue_en), 0);
        check("ovl_no_early_done", int'(done), 0);
        tick();
        b_hs = 1'b0;
        check("ovl_done", int'(done), 1);
        check("ovl_wr_cycles", int'(wr_cycles), 4);
        check("ovl_rd_cycles", int'(rd_cycles), 0);
        check("ovl_err", int'(err_code), 0);
        tick();
        check("ovl_idle_busy", int'(busy), 0);
        check("ovl_idle_done", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
